// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared encodings for the dual-port SRAM arbiter.
package sram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_e;
    typedef enum logic {PRIO_A, PRIO_B} prio_e;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/sram_dp_arbiter_if.sv
// sram_dp_arbiter_if: one requester's request/response bundle.
interface sram_dp_arbiter_if #(
    parameter int AW     = 8,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
);
    logic              req;
    logic              we;
    logic              ack;
    logic [MASK_W-1:0] wmask;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    modport master (output req, we, wmask, addr, wdata, input ack, rdata);
    modport slave (input req, we, wmask, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_arb_req_fsm.sv
// sram_arb_req_fsm: per-requester issue/capture/ack sequencer with read-data capture.
module sram_arb_req_fsm
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant,
    input  logic              port_i,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    output logic              idle,
    sram_dp_arbiter_if.slave  rq
);
    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              take;

    assign take = state_q == IDLE && grant;

    always_comb begin
        state_d = state_q == IDLE    ? (grant ? ISSUE : IDLE) :
                  state_q == ISSUE   ? CAPTURE :
                  state_q == CAPTURE ? ACK : IDLE;
        port_d  = take ? port_i : port_q;
        we_d    = take ? rq.we : we_q;
        // macro output is valid for the whole CAPTURE cycle, so latch at its end
        rdata_d = (state_q == CAPTURE && !we_q) ? (port_q == PORT1 ? din1 : din0) : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= PORT0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    assign idle     = state_q == IDLE;
    assign rq.ack   = state_q == ACK;
    assign rq.rdata = rdata_q;
endmodule

// File: rtl/sram_dp_arbiter.sv
// sram_dp_arbiter: shares one dual-port SRAM macro (RW port 0, R port 1) between requesters A and B
// with round-robin contention, same-address read-during-write deferral and registered macro drivers.
module sram_dp_arbiter
    import sram_arb_pkg::*;
#(
    parameter int  NO_OF_ROWS = 256,
    parameter int  DATA_W     = 32,
    parameter int  MASK_W     = DATA_W / 8,
    localparam int AW         = $clog2(NO_OF_ROWS)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              a_req_i,
    input  logic              b_req_i,
    input  logic              a_we_i,
    input  logic              b_we_i,
    input  logic [MASK_W-1:0] a_wmask_i,
    input  logic [MASK_W-1:0] b_wmask_i,
    input  logic [AW-1:0]     a_addr_i,
    input  logic [AW-1:0]     b_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              a_ack_o,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              ram_clk0,
    output logic              ram_clk1,
    output logic              ram_csb0,
    output logic              ram_csb1,
    output logic              ram_web0,
    output logic [MASK_W-1:0] ram_wmask0,
    output logic [AW-1:0]     ram_addr0,
    output logic [AW-1:0]     ram_addr1,
    output logic [DATA_W-1:0] ram_dout0,
    input  logic [DATA_W-1:0] ram_din0,
    input  logic [DATA_W-1:0] ram_din1
);
    sram_dp_arbiter_if #(.AW(AW), .DATA_W(DATA_W), .MASK_W(MASK_W)) ia ();
    sram_dp_arbiter_if #(.AW(AW), .DATA_W(DATA_W), .MASK_W(MASK_W)) ib ();

    assign ia.req   = a_req_i;
    assign ia.we    = a_we_i;
    assign ia.wmask = a_wmask_i;
    assign ia.addr  = a_addr_i;
    assign ia.wdata = a_wdata_i;
    assign ib.req   = b_req_i;
    assign ib.we    = b_we_i;
    assign ib.wmask = b_wmask_i;
    assign ib.addr  = b_addr_i;
    assign ib.wdata = b_wdata_i;
    assign a_ack_o   = ia.ack;
    assign a_rdata_o = ia.rdata;
    assign b_ack_o   = ib.ack;
    assign b_rdata_o = ib.rdata;

    prio_e             prio_q, prio_d;
    logic              a_idle, b_idle, ca, cb, ww, mix, hz;
    logic              ga, gb, pa, pb, a0, b0, a1, b1;
    logic              csb0_q, csb0_d, csb1_q, csb1_d, web0_q, web0_d;
    logic [MASK_W-1:0] wmask0_q, wmask0_d;
    logic [AW-1:0]     addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_W-1:0] dout0_q, dout0_d;

    assign ca  = a_idle && ia.req;
    assign cb  = b_idle && ib.req;
    assign ww  = ia.we && ib.we;
    assign mix = ia.we != ib.we;
    assign hz  = mix && ia.addr == ib.addr;

    always_comb begin
        ga     = ca;
        gb     = cb;
        pa     = ia.we ? PORT0 : PORT1;
        pb     = ib.we ? PORT0 : PORT1;
        prio_d = prio_q;
        if (ca && cb) begin
            if (ww) begin
                ga     = prio_q == PRIO_A;
                gb     = prio_q == PRIO_B;
                prio_d = prio_q == PRIO_A ? PRIO_B : PRIO_A;
            end else if (hz) begin
                // the reader retries next cycle so it observes the freshly written word
                ga     = ia.we;
                gb     = ib.we;
                prio_d = ia.we ? PRIO_B : PRIO_A;
            end else if (!mix) begin
                pa = prio_q == PRIO_A ? PORT1 : PORT0;
                pb = prio_q == PRIO_A ? PORT0 : PORT1;
            end
        end
    end

    assign a0 = ga && pa == PORT0;
    assign b0 = gb && pb == PORT0;
    assign a1 = ga && pa == PORT1;
    assign b1 = gb && pb == PORT1;

    always_comb begin
        csb0_d   = !(a0 || b0);
        csb1_d   = !(a1 || b1);
        web0_d   = a0 ? !ia.we : b0 ? !ib.we : 1'b1;
        wmask0_d = a0 ? ia.wmask : b0 ? ib.wmask : wmask0_q;
        addr0_d  = a0 ? ia.addr : b0 ? ib.addr : addr0_q;
        dout0_d  = a0 ? ia.wdata : b0 ? ib.wdata : dout0_q;
        addr1_d  = a1 ? ia.addr : b1 ? ib.addr : addr1_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            prio_q   <= PRIO_A;
            csb0_q   <= 1'b1;
            csb1_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            dout0_q  <= '0;
        end else begin
            prio_q   <= prio_d;
            csb0_q   <= csb0_d;
            csb1_q   <= csb1_d;
            web0_q   <= web0_d;
            wmask0_q <= wmask0_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            dout0_q  <= dout0_d;
        end
    end

    sram_arb_req_fsm #(.DATA_W(DATA_W)) u_fsm_a (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .grant  (ga),
        .port_i (pa),
        .din0   (ram_din0),
        .din1   (ram_din1),
        .idle   (a_idle),
        .rq     (ia.slave)
    );

    sram_arb_req_fsm #(.DATA_W(DATA_W)) u_fsm_b (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .grant  (gb),
        .port_i (pb),
        .din0   (ram_din0),
        .din1   (ram_din1),
        .idle   (b_idle),
        .rq     (ib.slave)
    );

    assign ram_clk0   = wb_clk_i;
    assign ram_clk1   = wb_clk_i;
    assign ram_csb0   = csb0_q;
    assign ram_csb1   = csb1_q;
    assign ram_web0   = web0_q;
    assign ram_wmask0 = wmask0_q;
    assign ram_addr0  = addr0_q;
    assign ram_addr1  = addr1_q;
    assign ram_dout0  = dout0_q;
endmodule

// File: doc/sram_dp_arbiter.md
# sram_dp_arbiter

- Shares one OpenRAM dual-port macro (port 0 RW, port 1 R-only, 32-bit words, byte write mask) between two independent requesters, A and B.
- Sits between the requesters and the macro, for example the Wishbone wrapper path and a logic-analyzer/test-sequencer path.
- Schedules each request onto a macro port and registers all macro control signals.
- Resolves contention round-robin, blocks read-during-write address hazards, and returns read data with a fixed latency.

## Interface
Parameters:
- NO_OF_ROWS, 256, macro depth in words; AW = clog2(NO_OF_ROWS).
- DATA_W, 32, word width.
- MASK_W, 4, write-mask width (DATA_W/8).

Ports (clock and reset first):
- wb_clk_i  in  1  single clock; the macro is clocked by it and samples on the rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- a_req_i, b_req_i  in  1  request; held high until the matching ack.
- a_we_i, b_we_i  in  1  1 = write, 0 = read.
- a_wmask_i, b_wmask_i  in  MASK_W  byte write mask.
- a_addr_i, b_addr_i  in  AW  word address.
- a_wdata_i, b_wdata_i  in  DATA_W  write data.
- a_ack_o, b_ack_o  out  1  one-cycle completion pulse.
- a_rdata_o, b_rdata_o  out  DATA_W  read data, valid while ack is high; held afterwards.
- ram_clk0, ram_clk1  out  1  = wb_clk_i.
- ram_csb0, ram_csb1  out  1  active-low chip selects, registered.
- ram_web0  out  1  active-low write enable, registered.
- ram_wmask0  out  MASK_W  registered.
- ram_addr0, ram_addr1  out  AW  registered.
- ram_dout0  out  DATA_W  write data to the macro, registered.
- ram_din0, ram_din1  in  DATA_W  macro read data.

## Operation
Per-requester FSM, one copy each for A and B:
- IDLE: req is sampled only in IDLE.
- IDLE -> ISSUE when granted.
- ISSUE -> CAPTURE -> ACK -> IDLE, one cycle each.
- At most one outstanding request per requester.
- A request still high in the ACK cycle is not a new request. It is re-sampled in IDLE after ACK.

Port allocation. Candidates are requesters in IDLE with req=1; the decision is evaluated every cycle.
- Single read goes to port 1. Single write goes to port 0.
- Write + read: write on port 0, read on port 1.
- Exception: if the two addresses are equal, the read is deferred. It stays IDLE and retries the next cycle.
- Read + read: the priority holder gets port 1, the other gets port 0. Both are granted.
- Write + write: the priority holder gets port 0. The other waits.

Round-robin pointer:
- Reset value: A has priority.
- When a requester is deferred (write+write, or a hazard), the pointer moves to the deferred requester.
- Otherwise the pointer is unchanged.

Granted ISSUE cycle, per port:
- csb = 0 on the assigned port.
- Port 0 also drives web0 = ~we, wmask0, addr0 and dout0 from the granted requester.
- Port 1 drives addr1.
- Ports not issuing in a cycle: csb = 1, web0 = 1, other fields hold their last value.

Data capture:
- At the end of CAPTURE, rdata latches din from the port the request used.
- Writes leave rdata unchanged.
- Each FSM records its port assignment (1 bit).

## Timing
- Grant edge E0, meaning req is high and the requester is IDLE at E0. Macro signals are valid during cycle E0-E1, and the macro samples at E1.
- din is valid during E1-E2 and is latched into rdata at E2.
- ack is high during E2-E3 and the FSM returns to IDLE at E3.
- Reads and writes have identical latency.
- Earliest back-to-back request from the same requester: grant at E3, giving 3 cycles per access per requester.
- Reset values: all csb = 1, web0 = 1, wmask0/addr0/addr1/dout0 = 0, acks = 0, rdata = 0, both FSMs IDLE, pointer = A.
- Reset asserted mid-operation takes effect immediately:
  - csb goes high asynchronously.
  - In-flight requests are dropped with no ack; requesters re-issue after reset.
- A write and a read to different addresses in the same cycle are both legal and complete in the same cycle.

## Structure
- Package sram_arb_pkg holds:
  - FSM state encoding: IDLE, ISSUE, CAPTURE, ACK.
  - Port-select constants: PORT0 = 0, PORT1 = 1.
  - The priority encoding: PRIO_A, PRIO_B.
- Sub-module sram_arb_req_fsm, instantiated twice: the per-requester FSM, port-select register and rdata capture.
- The top level holds the allocation logic, the round-robin pointer and the registered macro drivers.

## Test plan
- Single A write addr 0x05, wdata 0xDEADBEEF, wmask 0xF:
  - csb0 = 0, web0 = 0 for exactly one cycle after grant.
  - a_ack pulses 2 cycles after the grant edge.
- A then reads 0x05 -> csb1 = 0 for one cycle; a_ack with a_rdata = 0xDEADBEEF.
- A reads 0x10 and B reads 0x20 in the same cycle:
  - A is on port 1, B is on port 0.
  - Both acks arrive in the same cycle with the correct data.
- A and B both write 0x03 (values 0x1111_1111 / 0x2222_2222):
  - A is issued first, B one cycle later.
  - The pointer is now B, and a final read returns 0x2222_2222.
- A writes 0x07 while B reads 0x07:
  - B is deferred one cycle.
  - b_rdata equals the new value.
  - No cycle has csb0 and csb1 both low on the same address.
- wb_rst_n_i pulled low during CAPTURE:
  - csb0/csb1 go high immediately.
  - No ack is issued.
  - After release both FSMs are IDLE and the pointer is A.
